// File: rtl/serial_word_capture_if.sv
// Serial-in / word-out bundle for serial_word_capture: chip bit stream in,
// first-word-fall-through read handshake out.
interface serial_word_capture_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  serial_data;
    logic                  serial_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output serial_data, serial_valid, rd_ready,
        input  rd_data, rd_valid
    );

    modport slave (
        input  serial_data, serial_valid, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/serial_word_capture.sv
// Deserializes one chip serial stream MSB-first into DATA_WIDTH-bit words and
// queues them in a FWFT FIFO drained through a ready/valid handshake.
module serial_word_capture #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_WIDTH   = 5,
    parameter int TOTAL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    serial_word_capture_if.slave   bus,
    output logic [CNT_WIDTH-1:0]   fifo_count,
    output logic                   overflow,
    output logic [TOTAL_WIDTH-1:0] words_total,
    output logic                   partial_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic                  word_done;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign bus.rd_valid = (fifo_count != '0);
    assign partial_busy = (bit_cnt != '0);

    // NOTE: every signal here is assigned on every pass through the block, so
    // no path leaves a value held and no latch can be inferred.
    always_comb begin
        word       = {shift_q[DATA_WIDTH-2:0], bus.serial_data};
        word_done  = !clear && bus.serial_valid && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
        full       = (fifo_count == CNT_WIDTH'(FIFO_DEPTH));
        pop        = !clear && bus.rd_valid && bus.rd_ready;
        push       = word_done && (!full || pop);
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        // A word written into the slot that becomes the head must bypass the
        // memory, since the array still holds the old value at this edge.
        head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? word : mem[rd_ptr_nxt];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            words_total <= '0;
            bus.rd_data <= '0;
        end else begin
            if (bus.serial_valid) begin
                shift_q <= word;
                bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;

            if (push && !pop)      fifo_count <= fifo_count + CNT_WIDTH'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_WIDTH'(1);

            if (word_done && !push) overflow <= 1'b1;
            if (word_done && (words_total != '1)) words_total <= words_total + TOTAL_WIDTH'(1);

            bus.rd_data <= head_nxt;
        end
    end

    // NOTE: the storage array has no reset; fifo_count and the pointers alone
    // decide which entries are meaningful, so clearing it would only add cost.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= word;
    end
endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench for serial_word_capture: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_serial_word_capture;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] words_total;
    logic        partial_busy;

    serial_word_capture_if #(.DATA_WIDTH(DW)) bus ();

    serial_word_capture #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (5),
        .TOTAL_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .words_total (words_total),
        .partial_busy(partial_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of stored words plus the bits of the word in progress.
    logic [15:0] m_q [$];
    logic [15:0] m_shift = '0;
    int          m_bits  = 0;
    bit          m_ovf   = 0;
    int          m_total = 0;
    bit          m_after_reset = 0;

    logic [15:0] popped [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic sv, input logic sd, input logic rr,
                              input logic cl, input logic rn);
        bit done;
        if (!rn || cl) begin
            m_q.delete();
            m_shift = '0;
            m_bits  = 0;
            m_ovf   = 0;
            m_total = 0;
            m_after_reset = 1;
            return;
        end
        m_after_reset = 0;
        done = 0;
        if (sv) begin
            m_shift = {m_shift[14:0], sd};
            m_bits++;
            if (m_bits == DW) begin
                done   = 1;
                m_bits = 0;
            end
        end
        if (rr && m_q.size() > 0) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_shift);
            else m_ovf = 1;
            if (m_total < 65535) m_total++;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic cycle(input logic sv, input logic sd, input logic rr,
                         input logic cl = 1'b0, input logic rn = 1'b1);
        rst_n            = rn;
        clear            = cl;
        bus.serial_valid = sv;
        bus.serial_data  = sd;
        bus.rd_ready     = rr;
        if (bus.rd_valid && rr && rn && !cl) popped.push_back(bus.rd_data);
        @(posedge clk);
        model_step(sv, sd, rr, cl, rn);
        #1;
        check("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(m_q[0]));
        else if (m_after_reset) check("rd_data_reset", 32'(bus.rd_data), 32'h0);
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("words_total", 32'(words_total), 32'(m_total));
        check("partial_busy", 32'(partial_busy), 32'(m_bits != 0));
    endtask

    task automatic send_word(input logic [15:0] w, input logic rr_last = 1'b0,
                             input int gap_a = -1, input int gap_b = -1);
        for (int i = 0; i < DW; i++) begin
            cycle(1'b1, w[15-i], (i == DW - 1) ? rr_last : 1'b0);
            if (i + 1 == gap_a || i + 1 == gap_b) repeat (3) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input int n);
        popped.delete();
        repeat (n) cycle(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.serial_valid = 1'b0;
        bus.serial_data  = 1'b0;
        bus.rd_ready     = 1'b0;

        // Reset, then a single word with no gaps.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(16'hA5C3);
        check("a5c3_data", 32'(bus.rd_data), 32'hA5C3);
        check("a5c3_count", 32'(fifo_count), 32'd1);
        check("a5c3_total", 32'(words_total), 32'd1);

        // Same word with idle gaps mid-word.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(16'hA5C3, 1'b0, 4, 11);
        check("gap_data", 32'(bus.rd_data), 32'hA5C3);
        check("gap_total", 32'(words_total), 32'd1);

        // Overflow: 17 words into a 16-deep FIFO, then drain.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) send_word(16'(i));
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_total", 32'(words_total), 32'd17);
        drain(20);
        check("ovf_drain_len", 32'(popped.size()), 32'd16);
        for (int i = 0; i < popped.size(); i++) check("ovf_drain_order", 32'(popped[i]), 32'(i + 1));

        // Push and pop together while full: accepted, and wraps the pointers.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_word(16'h0100 + 16'(i));
        send_word(16'h1234, 1'b1);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_count", 32'(fifo_count), 32'd16);
        drain(20);
        check("full_pp_len", 32'(popped.size()), 32'd16);
        if (popped.size() == 16) check("full_pp_last", 32'(popped[15]), 32'h1234);

        // Clear mid-word discards the partial bits.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        send_word(16'h00FF);
        check("clr_data", 32'(bus.rd_data), 32'h00FF);
        check("clr_count", 32'(fifo_count), 32'd1);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_total", 32'(words_total), 32'd1);

        // Reset with five words stored and overflow set.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) send_word(16'h0F00 + 16'(i));
        drain(11);
        check("pre_rst_count", 32'(fifo_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(bus.rd_data), 32'd0);
        send_word(16'hBEEF);
        check("beef_data", 32'(bus.rd_data), 32'hBEEF);

        // Random traffic with varying drain rate, occasional clear and reset.
        for (int blk = 0; blk < 15; blk++) begin
            int density;
            density = (blk % 3 == 0) ? 5 : (blk % 3 == 1) ? 50 : 95;
            for (int c = 0; c < 200; c++) begin
                cycle(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                      1'($urandom_range(99) < density),
                      1'($urandom_range(249) == 0), 1'($urandom_range(399) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
